// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
// Shared pipeline definitions used by fetch, IF/ID, the stall unit and the
// instruction prefetch queue.
//   FQ_INSTR_W / FQ_PC_W : default instruction and next-PC widths
//   NOP_INSTR            : instruction presented when nothing is valid
//   fq_op_e              : per-cycle storage operation (store / read)
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

  localparam int unsigned FQ_INSTR_W = 32;
  localparam int unsigned FQ_PC_W    = 32;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

  // Encoded as {store, read} so it can be built directly from the two strobes.
  typedef enum logic [1:0] {
    FQ_HOLD = 2'b00,
    FQ_READ = 2'b01,
    FQ_STORE = 2'b10,
    FQ_BOTH = 2'b11
  } fq_op_e;

endpackage : fetch_queue_pkg

// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
// Handshake bundle between the fetch stage (producer), the IF/ID register
// (consumer) and the prefetch queue.
//   in_valid/in_ready/in_instr/in_pc    : fetch -> queue push side
//   out_valid/out_ready/out_instr/out_pc: queue -> IF/ID pop side
//   flush                               : taken branch in decode
//   count                               : queue occupancy
// Modports: master = fetch/IF-ID side, slave = the queue itself.
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               flush;
  logic [CNT_W-1:0]   count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count
  );

endinterface : fetch_queue_if

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Instruction prefetch queue between fetch and the IF/ID register. Buffers
// instruction/next-PC pairs while decode is stalled and drops everything on
// a taken-branch flush. Circular buffer with write/read pointers and an
// explicit occupancy counter.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   fq    : fetch_queue_if.slave handshake bundle (push, pop, flush, count)
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN : when defined, an empty queue forwards in_* to
//                           out_* combinationally; a bypassed entry taken in
//                           the same cycle is never stored.
//   Undefined (default)   : out_* and in_ready depend on registers only.
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = FQ_INSTR_W,
  parameter int PC_W    = FQ_PC_W
) (
  input logic        clk,
  input logic        reset,
  fetch_queue_if.slave fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);
  localparam logic [INSTR_W-1:0] NOP_W    = INSTR_W'(NOP_INSTR);

  logic [INSTR_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]    r_pc    [DEPTH];
  logic [PTR_W-1:0]   r_wp;
  logic [PTR_W-1:0]   r_rp;
  logic [CNT_W-1:0]   r_count;

  logic   w_empty;
  logic   w_full;
  logic   w_bypass;
  logic   w_valid;
  logic   w_push;
  logic   w_take;
  logic   w_store;
  logic   w_read;
  fq_op_e w_op;

  // Bypass qualifier: only an empty, non-flushed queue may forward.
`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & fq.in_valid & ~fq.flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Occupancy flags and handshake strobes.
  always_comb begin
    w_empty = (r_count == {CNT_W{1'b0}});
    w_full  = (r_count == FULL_CNT);
    w_valid = w_bypass | ~w_empty;
    // No pass-through when full: a same-cycle pop does not free a slot.
    w_push  = fq.in_valid & ~w_full;
    w_take  = w_valid & fq.out_ready;
    // A bypassed entry consumed this cycle never touches storage.
    w_store = w_push & ~(w_bypass & fq.out_ready);
    w_read  = w_take & ~w_bypass;
    w_op    = fq_op_e'({w_store, w_read});
  end

  // Output presentation: bypass data, head entry, or NOP/zero when idle.
  always_comb begin
    fq.in_ready = ~w_full;
    fq.count    = r_count;
    fq.out_valid = w_valid;
    if (w_bypass) begin
      fq.out_instr = fq.in_instr;
      fq.out_pc    = fq.in_pc;
    end else if (!w_empty) begin
      fq.out_instr = r_instr[r_rp];
      fq.out_pc    = r_pc[r_rp];
    end else begin
      fq.out_instr = NOP_W;
      fq.out_pc    = {PC_W{1'b0}};
    end
  end

  // Pointer and occupancy state; flush overrides any push/pop in its cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wp    <= {PTR_W{1'b0}};
      r_rp    <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else if (fq.flush) begin
      r_wp    <= {PTR_W{1'b0}};
      r_rp    <= {PTR_W{1'b0}};
      r_count <= {CNT_W{1'b0}};
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (w_store) begin
        r_wp <= r_wp + PTR_ONE;
      end
      if (w_read) begin
        r_rp <= r_rp + PTR_ONE;
      end
      case (w_op)
        FQ_STORE: r_count <= r_count + CNT_ONE;
        FQ_READ:  r_count <= r_count - CNT_ONE;
        default:  r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed through r_count-gated reads.
  always_ff @(posedge clk) begin
    if (w_store && !fq.flush) begin
      r_instr[r_wp] <= fq.in_instr;
      r_pc[r_wp]    <= fq.in_pc;
    end
  end

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue. A driver issues one stimulus per cycle
// and appends every accepted instruction to an expected FIFO; a monitor
// samples the outputs late in each cycle, checks them against that FIFO and
// retires entries as they are consumed. Honours FETCH_QUEUE_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 32;
  localparam int PW    = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic reset;

  fetch_queue_if #(.DEPTH(DEPTH), .INSTR_W(IW), .PC_W(PW)) fq ();

  fetch_queue #(.DEPTH(DEPTH), .INSTR_W(IW), .PC_W(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .fq    (fq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] exp_q[$];
  bit          push_now;
  int          n_checks;
  int          n_errors;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One stimulus per cycle; accepted pushes go to the expected FIFO.
  task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit fl);
    @(negedge clk);
    fq.in_valid  = v;
    fq.in_instr  = ins;
    fq.in_pc     = pc;
    fq.out_ready = rdy;
    fq.flush     = fl;
    push_now = v && !fl && (exp_q.size() != DEPTH);
    if (push_now) exp_q.push_back({ins, pc});
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(fq.out_valid), 64'd0);
    chk({tag, "_count"},     64'(fq.count),     64'd0);
    chk({tag, "_in_ready"},  64'(fq.in_ready),  64'd1);
    chk({tag, "_out_instr"}, 64'(fq.out_instr), 64'd0);
    chk({tag, "_out_pc"},    64'(fq.out_pc),    64'd0);
  endtask

  // Asynchronous reset between edges; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    fq.in_valid  = 1'b0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
    push_now     = 1'b0;
    #1;
    check_idle_outputs("reset_mid");
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: compares the presented head against the expected FIFO.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!reset) begin
        int          vis;
        bit          byp;
        bit          ev;
        logic [63:0] head;
        vis  = exp_q.size() - (push_now ? 1 : 0);
        byp  = BYP && (vis == 0) && fq.in_valid && !fq.flush;
        ev   = (vis != 0) || byp;
        head = ev ? exp_q[0] : 64'd0;
        chk("out_valid", 64'(fq.out_valid), 64'(ev));
        chk("out_instr", 64'(fq.out_instr), 64'(head[63:32]));
        chk("out_pc",    64'(fq.out_pc),    64'(head[31:0]));
        chk("count",     64'(fq.count),     64'(vis));
        chk("in_ready",  64'(fq.in_ready),  64'(vis != DEPTH));
        if (fq.flush) exp_q.delete();
        else if (ev && fq.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    push_now = 1'b0;
    reset = 1'b1;
    fq.in_valid  = 1'b0;
    fq.in_instr  = 32'h0;
    fq.in_pc     = 32'h0;
    fq.out_ready = 1'b0;
    fq.flush     = 1'b0;
    #1;
    check_idle_outputs("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // Reset mid-fill.
    drive(1'b1, 32'h8C01_0004, 32'h0000_0004, 1'b0, 1'b0);
    drive(1'b1, 32'h8C02_0008, 32'h0000_0008, 1'b0, 1'b0);
    do_reset();

    // Fill with five (fifth rejected), then drain in order.
    for (int i = 0; i < 5; i++)
      drive(1'b1, 32'h2000_0000 + 32'(i), 32'h0040_0000 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Steady stream at occupancy 2.
    drive(1'b1, 32'h3000_0000, 32'h0000_1000, 1'b0, 1'b0);
    drive(1'b1, 32'h3000_0001, 32'h0000_1004, 1'b0, 1'b0);
    for (int i = 2; i < 22; i++)
      drive(1'b1, 32'h3000_0000 + 32'(i), 32'h0000_1000 + 32'(4 * i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush at count 3 with simultaneous push/pop, then a fresh push.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 32'h4000_0000 + 32'(i), 32'h0000_2000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'h4000_00FF, 32'h0000_20FC, 1'b1, 1'b1);
    drive(1'b1, 32'h1022_0003, 32'h0000_3000, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Full plus pop: push rejected, count drops to 3.
    for (int i = 0; i < 4; i++)
      drive(1'b1, 32'h5000_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 1'b0, 1'b0);
    drive(1'b1, 32'h5000_00FF, 32'h0000_40FC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Empty queue, push and pop together (bypass case when enabled).
    drive(1'b1, 32'h0022_1820, 32'h0000_5004, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b1, 32'h0022_1824, 32'h0000_5008, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
    for (int i = 0; i < DEPTH + 1; i++)
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_queue
